// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller, the decoder and the ALU:
// mul/div opcodes and the occupancy FSM state type.
package pipe_hazard_ctrl_pkg;

    typedef logic [1:0] md_op_t;

    localparam md_op_t MD_NONE = 2'b00;
    localparam md_op_t MD_MUL  = 2'b01;
    localparam md_op_t MD_DIV  = 2'b10;

    typedef logic [0:0] md_state_t;

    localparam md_state_t ST_IDLE = 1'b0;
    localparam md_state_t ST_BUSY = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard inputs and segment-register stall/clear outputs.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_ren;
    logic       id_rt_ren;
    logic [1:0] id_rhilo;
    logic       ex_load;
    logic       ex_regwen;
    logic [5:0] ex_wreg;
    md_op_t     ex_md_op;
    logic       exc_flush;

    logic       if_stall;
    logic       id_stall;
    logic       ex_stall;
    logic       id_ex_clr;
    logic       ex_mem_clr;
    logic       if_id_clr;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_rs, id_rt, id_rs_ren, id_rt_ren, id_rhilo,
               ex_load, ex_regwen, ex_wreg, ex_md_op, exc_flush,
        input  if_stall, id_stall, ex_stall, id_ex_clr, ex_mem_clr,
               if_id_clr, md_busy, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_rs_ren, id_rt_ren, id_rhilo,
               ex_load, ex_regwen, ex_wreg, ex_md_op, exc_flush,
        output if_stall, id_stall, ex_stall, id_ex_clr, ex_mem_clr,
               if_id_clr, md_busy, md_done
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_occupancy_fsm.sv
// Mul/div occupancy tracker: busy from the issue cycle through N cycles total,
// md_done on the last one. A flush or reset abandons the operation silently.
module md_occupancy_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic   clk,
    input  logic   resetn,
    input  md_op_t md_op,
    input  logic   exc_flush,
    output logic   md_busy,
    output logic   md_done
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES));
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_CYCLES - 2);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             start;

    // Issue cycle counts as busy so the stall already covers it.
    assign start   = resetn & (state == ST_IDLE) & !exc_flush &
                     ((md_op == MD_MUL) | (md_op == MD_DIV));
    assign md_busy = (state == ST_BUSY) | start;
    assign md_done = (state == ST_BUSY) & (cnt == '0) & !exc_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_BUSY;
                        cnt   <= (md_op == MD_DIV) ? DIV_INIT : MUL_INIT;
                    end
                end
                default: begin
                    if (exc_flush || cnt == '0) state <= ST_IDLE;
                    else                        cnt   <= cnt - 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for if_id, id_ex and ex_mem: load-use and HI/LO
// hazard detection plus the flush > mul/div > hazard priority mux.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic               clk,
    input  logic               resetn,
    pipe_hazard_ctrl_if.slave  hz
);

    logic       md_busy;
    logic       md_done;
    logic [4:0] ex_gpr;
    logic       lu;
    logic       hilo;
    logic       unused_wreg_msb;

    md_occupancy_fsm #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_fsm (
        .clk       (clk),
        .resetn    (resetn),
        .md_op     (hz.ex_md_op),
        .exc_flush (hz.exc_flush),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    assign ex_gpr          = hz.ex_wreg[4:0];
    assign unused_wreg_msb = hz.ex_wreg[5];

    assign lu   = hz.ex_load & hz.ex_regwen & (ex_gpr != 5'd0) &
                  ((hz.id_rs_ren & (hz.id_rs == ex_gpr)) |
                   (hz.id_rt_ren & (hz.id_rt == ex_gpr)));
    // A HI/LO read in the md_done cycle picks up the forwarded result.
    assign hilo = (|hz.id_rhilo) & md_busy & !md_done;

    assign hz.md_busy = md_busy;
    assign hz.md_done = md_done;

    always_comb begin
        hz.if_stall   = 1'b0;
        hz.id_stall   = 1'b0;
        hz.ex_stall   = 1'b0;
        hz.id_ex_clr  = 1'b0;
        hz.ex_mem_clr = 1'b0;
        hz.if_id_clr  = 1'b0;
        if (!resetn) begin
            // everything held low while in reset
        end else if (hz.exc_flush) begin
            hz.if_id_clr  = 1'b1;
            hz.id_ex_clr  = 1'b1;
            hz.ex_mem_clr = 1'b1;
        end else if (md_busy && !md_done) begin
            hz.if_stall   = 1'b1;
            hz.id_stall   = 1'b1;
            hz.ex_stall   = 1'b1;
            hz.ex_mem_clr = 1'b1;
        end else if (lu || hilo) begin
            hz.if_stall  = 1'b1;
            hz.id_stall  = 1'b1;
            hz.id_ex_clr = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MUL_CYCLES=4, DIV_CYCLES=33).
// Output vector: {if_stall,id_stall,ex_stall,id_ex_clr,ex_mem_clr,if_id_clr,md_busy,md_done}.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_LU    = 8'b1101_0000;
    localparam logic [7:0] O_MDSTL = 8'b1110_1010;
    localparam logic [7:0] O_DONE  = 8'b0000_0011;
    localparam logic [7:0] O_FLB   = 8'b0001_1110;
    localparam logic [7:0] O_FL    = 8'b0001_1100;

    logic clk = 1'b0;
    logic resetn;
    int   tests = 0;
    int   fails = 0;
    int   busy_cnt;
    int   stall_cnt;
    int   done_cnt;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz)
    );

    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {hz.if_stall, hz.id_stall, hz.ex_stall, hz.id_ex_clr,
                  hz.ex_mem_clr, hz.if_id_clr, hz.md_busy, hz.md_done};

    task automatic chk(input string tag, input logic [7:0] exp);
        #1;
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.id_rs = 5'd0;  hz.id_rt = 5'd0;
        hz.id_rs_ren = 1'b0;  hz.id_rt_ren = 1'b0;
        hz.id_rhilo = 2'b00;
        hz.ex_load = 1'b0;  hz.ex_regwen = 1'b0;  hz.ex_wreg = 6'd0;
        hz.ex_md_op = 2'b00;  hz.exc_flush = 1'b0;
    endtask

    task automatic set_lu(input logic [5:0] wreg, input logic [4:0] rs, input logic rs_ren);
        clear_in();
        hz.ex_load = 1'b1;  hz.ex_regwen = 1'b1;  hz.ex_wreg = wreg;
        hz.id_rs = rs;  hz.id_rs_ren = rs_ren;
    endtask

    initial begin
        // reset: outputs low even with hazard/issue inputs present
        resetn = 1'b0;
        set_lu(6'd9, 5'd9, 1'b1);
        hz.ex_md_op = 2'b10;
        chk("reset_hold", O_IDLE);
        #7 clear_in();
        resetn = 1'b1;
        tick();
        chk("post_reset", O_IDLE);

        // T1 load-use on rs, then on rt, then with reserved wreg bit set
        set_lu(6'd9, 5'd9, 1'b1);
        chk("lu_rs", O_LU);
        tick();  clear_in();
        chk("lu_rs_after", O_IDLE);
        tick();  set_lu(6'd9, 5'd0, 1'b0);
        hz.id_rt = 5'd9;  hz.id_rt_ren = 1'b1;
        chk("lu_rt", O_LU);
        tick();  set_lu(6'b10_1001, 5'd9, 1'b1);
        chk("lu_wreg_b5_ignored", O_LU);

        // T2 no stall cases
        tick();  set_lu(6'd0, 5'd0, 1'b1);
        chk("lu_r0", O_IDLE);
        tick();  set_lu(6'd9, 5'd9, 1'b0);
        chk("lu_no_ren", O_IDLE);
        tick();  set_lu(6'd9, 5'd9, 1'b1);  hz.ex_regwen = 1'b0;
        chk("lu_no_regwen", O_IDLE);
        tick();  set_lu(6'd9, 5'd8, 1'b1);
        chk("lu_diff_reg", O_IDLE);
        tick();  set_lu(6'd9, 5'd9, 1'b1);  hz.ex_load = 1'b0;
        chk("lu_not_load", O_IDLE);

        // T3 DIV: 33 busy cycles, 32 stall cycles, md_done on the 33rd
        tick();  clear_in();  hz.ex_md_op = 2'b10;
        busy_cnt = 0;  stall_cnt = 0;  done_cnt = 0;
        for (int i = 1; i <= 33; i++) begin
            chk($sformatf("div_cyc%0d", i), (i < 33) ? O_MDSTL : O_DONE);
            busy_cnt  += int'(hz.md_busy);
            stall_cnt += int'(hz.ex_stall);
            done_cnt  += int'(hz.md_done);
            tick();
        end
        clear_in();
        chk("div_after", O_IDLE);
        tests++;
        assert (busy_cnt == 33 && stall_cnt == 32 && done_cnt == 1)
        else begin
            fails++;
            $error("FAIL div_counts observed=%0d/%0d/%0d expected=33/32/1",
                   busy_cnt, stall_cnt, done_cnt);
        end

        // T4 MUL with HI/LO reader in ID: stalled until md_done, released there
        tick();  hz.ex_md_op = 2'b01;  hz.id_rhilo = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mul_hilo_cyc%0d", i), (i < 4) ? O_MDSTL : O_DONE);
            tick();
        end
        clear_in();  hz.id_rhilo = 2'b01;
        chk("hilo_idle", O_IDLE);

        // T5 flush on busy cycle 5 of a div
        tick();  clear_in();  hz.ex_md_op = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("div_fl_cyc%0d", i), O_MDSTL);
            tick();
        end
        hz.exc_flush = 1'b1;
        chk("div_flush", O_FLB);
        tick();  clear_in();
        for (int i = 0; i < 35; i++) begin
            chk($sformatf("div_flushed%0d", i), O_IDLE);
            tick();
        end

        // flush with simultaneous issue: flush wins, BUSY not entered
        hz.ex_md_op = 2'b01;  hz.exc_flush = 1'b1;
        chk("flush_issue", O_FL);
        tick();  clear_in();
        chk("flush_issue_next", O_IDLE);
        // flush beats a load-use hazard
        tick();  set_lu(6'd9, 5'd9, 1'b1);  hz.exc_flush = 1'b1;
        chk("flush_over_lu", O_FL);

        // T6 async reset mid-div, released off-edge, then a fresh MUL
        tick();  clear_in();  hz.ex_md_op = 2'b10;
        chk("div_rst_cyc1", O_MDSTL);
        tick();
        chk("div_rst_cyc2", O_MDSTL);
        tick();
        resetn = 1'b0;
        chk("async_reset", O_IDLE);
        tick();
        resetn = 1'b1;  hz.ex_md_op = 2'b00;
        chk("reset_released", O_IDLE);
        tick();  hz.ex_md_op = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("mul_post_rst%0d", i), (i < 4) ? O_MDSTL : O_DONE);
            tick();
        end
        clear_in();
        chk("final_idle", O_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
